// File: rtl/usb_in_arbiter.sv
// Two-channel USB IN endpoint arbiter: moves bytes from two channel FIFOs to one
// IN endpoint, one whole packet at a time, with round-robin grant and short-packet timeout.
module usb_in_arbiter #(
   parameter int WIDTH    = 8,
   parameter int PTRWIDTH = 2,
   parameter int MAXPKT   = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ch0_empty,
   input  logic [PTRWIDTH:0]   ch0_usedw,
   input  logic [WIDTH-1:0]    ch0_dout,
   input  logic                ch0_fifo_valid,
   output logic                ch0_load,
   input  logic                ch1_empty,
   input  logic [PTRWIDTH:0]   ch1_usedw,
   input  logic [WIDTH-1:0]    ch1_dout,
   input  logic                ch1_fifo_valid,
   output logic                ch1_load,
   output logic [WIDTH-1:0]    tx_data,
   output logic                tx_valid,
   output logic                tx_last,
   output logic                tx_ch,
   input  logic                tx_ready,
   output logic                busy
);
   localparam int CW = $clog2(MAXPKT) + 1;
   localparam int AW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_SEND = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   tx_last_q, tx_last_d;
   logic                   tx_ch_q, tx_ch_d;
   logic                   last_q, last_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [1:0][AW-1:0]     age_q, age_d;

   logic [1:0]             empty, elig, gnt;
   logic [1:0][PTRWIDTH:0] usedw;
   logic                   grant_ch;
   logic                   g_valid, g_empty;
   logic [WIDTH-1:0]       g_dout;

   assign empty    = {ch1_empty, ch0_empty};
   assign usedw[0] = ch0_usedw;
   assign usedw[1] = ch1_usedw;

   // Eligibility, round-robin choice and per-channel age counters.
   always_comb begin
      elig  = '0;
      gnt   = '0;
      age_d = age_q;
      for (int i = 0; i < 2; i++)
         elig[i] = (32'(usedw[i]) >= MAXPKT) || (!empty[i] && age_q[i] == AW'(TIMEOUT));
      grant_ch = (elig[0] && elig[1]) ? ~last_q : elig[1];
      if (state_q == S_IDLE && |elig)
         gnt[grant_ch] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (empty[i] || gnt[i])
            age_d[i] = '0;
         else if (age_q[i] != AW'(TIMEOUT))
            age_d[i] = age_q[i] + AW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      tx_ch_d    = tx_ch_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      g_valid    = tx_ch_q ? ch1_fifo_valid : ch0_fifo_valid;
      g_empty    = tx_ch_q ? ch1_empty      : ch0_empty;
      g_dout     = tx_ch_q ? ch1_dout       : ch0_dout;
      case (state_q)
         S_IDLE: begin
            if (|elig) begin
               state_d = S_LOAD;
               tx_ch_d = grant_ch;
               cnt_d   = '0;
            end
         end
         S_LOAD: state_d = S_WAIT;
         S_WAIT: begin
            if (g_valid) begin
               tx_data_d  = g_dout;
               tx_valid_d = 1'b1;
               // A drained FIFO closes the packet short.
               tx_last_d  = ((cnt_q + CW'(1)) == CW'(MAXPKT)) || g_empty;
               state_d    = S_SEND;
            end
         end
         default: begin
            if (tx_ready) begin
               cnt_d      = cnt_q + CW'(1);
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (tx_last_q) begin
                  state_d = S_IDLE;
                  last_d  = tx_ch_q;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         tx_ch_q    <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         age_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         tx_ch_q    <= tx_ch_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         age_q      <= age_d;
      end
   end

   assign ch0_load = (state_q == S_LOAD) && !tx_ch_q;
   assign ch1_load = (state_q == S_LOAD) &&  tx_ch_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign tx_ch    = tx_ch_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Bench for usb_in_arbiter: behavioural FIFOs on both channels, a packet-level
// reference model feeding an expected-byte queue, and a handshake monitor.
module tb_usb_in_arbiter;
   logic       clk, rst;
   logic       ch0_empty, ch0_fifo_valid, ch0_load;
   logic       ch1_empty, ch1_fifo_valid, ch1_load;
   logic [2:0] ch0_usedw, ch1_usedw;
   logic [7:0] ch0_dout, ch1_dout, tx_data;
   logic       tx_valid, tx_last, tx_ch, tx_ready, busy;

   usb_in_arbiter #(.WIDTH(8), .PTRWIDTH(2), .MAXPKT(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .ch0_empty(ch0_empty), .ch0_usedw(ch0_usedw), .ch0_dout(ch0_dout),
      .ch0_fifo_valid(ch0_fifo_valid), .ch0_load(ch0_load),
      .ch1_empty(ch1_empty), .ch1_usedw(ch1_usedw), .ch1_dout(ch1_dout),
      .ch1_fifo_valid(ch1_fifo_valid), .ch1_load(ch1_load),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ch(tx_ch),
      .tx_ready(tx_ready), .busy(busy)
   );

   typedef struct packed {logic ch; logic [7:0] data; logic last;} exp_t;

   exp_t       expq[$];
   logic [7:0] fq0[$], fq1[$];
   logic [7:0] ba [4], bb [4];
   int         total = 0, bad = 0;
   int         ld0_cnt = 0, ld1_cnt = 0, hs_cnt = 0, pkt_len = 0, max_len = 0;
   int         rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
   bit         ld0_s = 0, ld1_s = 0;
   bit         mptr = 1;       // model last-grant pointer

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   // Channel FIFO models: a load seen in a cycle pops one byte into dout for one cycle.
   always @(negedge clk) begin
      ld0_s = ch0_load;
      ld1_s = ch1_load;
      if (ch0_load) ld0_cnt++;
      if (ch1_load) ld1_cnt++;
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         fq0.delete(); fq1.delete();
         ch0_fifo_valid = 0; ch1_fifo_valid = 0;
      end else begin
         ch0_fifo_valid = 0; ch1_fifo_valid = 0;
         if (ld0_s && fq0.size() > 0) begin ch0_dout = fq0.pop_front(); ch0_fifo_valid = 1; end
         if (ld1_s && fq1.size() > 0) begin ch1_dout = fq1.pop_front(); ch1_fifo_valid = 1; end
      end
      ld0_s = 0; ld1_s = 0;
      ch0_empty = (fq0.size() == 0); ch0_usedw = 3'(fq0.size());
      ch1_empty = (fq1.size() == 0); ch1_usedw = 3'(fq1.size());
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   // Monitor: every accepted byte is matched against the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         expq.delete();
         pkt_len = 0;
      end else if (tx_valid && tx_ready) begin
         hs_cnt++;
         pkt_len++;
         if (pkt_len > max_len) max_len = pkt_len;
         if (tx_last) pkt_len = 0;
         if (expq.size() == 0) begin
            chk("unexpected_byte", tx_data, 0);
         end else begin
            e = expq.pop_front();
            chk("tx_ch", tx_ch, e.ch);
            chk("tx_data", tx_data, e.data);
            chk("tx_last", tx_last, e.last);
         end
      end
   end

   // Reference model: each non-empty channel yields one packet of all its bytes
   // (n <= MAXPKT). A full channel beats a partial one; equal kinds tie by pointer.
   task automatic issue_round(input logic [7:0] b0 [4], input int n0,
                              input logic [7:0] b1 [4], input int n1);
      int first;
      exp_t e;
      for (int k = 0; k < n0; k++) fq0.push_back(b0[k]);
      for (int k = 0; k < n1; k++) fq1.push_back(b1[k]);
      if (n0 > 0 && n1 > 0) begin
         if (n0 == 4 && n1 != 4)      first = 0;
         else if (n1 == 4 && n0 != 4) first = 1;
         else                         first = mptr ? 0 : 1;
      end else begin
         first = (n0 > 0) ? 0 : 1;
      end
      for (int p = 0; p < 2; p++) begin
         int c, n;
         c = (p == 0) ? first : 1 - first;
         n = (c == 0) ? n0 : n1;
         for (int k = 0; k < n; k++) begin
            e.ch   = 1'(c);
            e.data = (c == 0) ? b0[k] : b1[k];
            e.last = (k == n - 1);
            expq.push_back(e);
         end
         if (n > 0) mptr = 1'(c);
      end
   endtask

   task automatic wait_done(input int bound, input string nm);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge clk);
         if (expq.size() == 0 && !busy && fq0.size() == 0 && fq1.size() == 0) break;
      end
      chk({nm, "_complete"}, (i < bound) ? 1 : 0, 1);
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if (tx_valid) ok = 1;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_tx_last"},  tx_last, 0);
      chk({tag, "_tx_data"},  tx_data, 0);
      chk({tag, "_tx_ch"},    tx_ch, 0);
      chk({tag, "_busy"},     busy, 0);
      chk({tag, "_loads"},    {ch1_load, ch0_load}, 0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1 rst = 1;
      mptr = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, l1, h, got, n0, n1;
      bit ok, stable;
      logic [7:0] d;
      logic l;
      rst = 1; tx_ready = 1;
      ch0_empty = 1; ch1_empty = 1; ch0_usedw = 0; ch1_usedw = 0;
      ch0_dout = 0; ch1_dout = 0; ch0_fifo_valid = 0; ch1_fifo_valid = 0;
      repeat (3) @(negedge clk);
      check_reset_outs("reset");
      @(posedge clk); #1 rst = 0;
      @(posedge clk); #1;

      // Full packet on ch0
      l0 = ld0_cnt; l1 = ld1_cnt;
      ba = '{8'hAA, 8'h11, 8'h22, 8'h33};
      issue_round(ba, 4, bb, 0);
      wait_done(200, "full");
      chk("full_ch0_loads", ld0_cnt - l0, 4);
      chk("full_ch1_loads", ld1_cnt - l1, 0);

      // Tie after reset: ch0 first, then ch1
      apply_reset();
      ba = '{8'h01, 8'h02, 8'h03, 8'h04};
      bb = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
      issue_round(ba, 4, bb, 4);
      wait_done(300, "tie");

      // Timeout flush of a lone byte on ch1
      @(posedge clk); #1;
      l0 = ld0_cnt;
      bb[0] = 8'h5A;
      issue_round(ba, 0, bb, 1);
      got = -1;
      for (int i = 0; i < 5 && ch1_empty; i++) @(negedge clk);
      for (int i = 0; i < 40 && got < 0; i++) begin
         if (i > 0) @(negedge clk);
         if (ch1_load) got = i;
      end
      total++;
      if (got < 16 || got > 18) begin
         bad++;
         $display("FAIL timeout_load_cycle actual=%0d required=16..18", got);
      end
      wait_done(200, "timeout");
      chk("timeout_ch0_loads", ld0_cnt - l0, 0);

      // Back-pressure on byte 2
      rdy_mode = 2;
      @(posedge clk); #1;
      ba = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
      issue_round(ba, 4, bb, 0);
      wait_valid(200, ok);
      chk("bp_byte1_valid", ok, 1);
      rdy_mode = 0;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) ok = 1;
      end
      chk("bp_byte1_hs", ok, 1);
      rdy_mode = 2;
      @(posedge clk); #2;
      wait_valid(20, ok);
      chk("bp_byte2_valid", ok, 1);
      d = tx_data; l = tx_last; l0 = ld0_cnt + ld1_cnt; stable = 1;
      repeat (10) begin
         @(negedge clk);
         if (!tx_valid || tx_data !== d || tx_last !== l || !busy) stable = 0;
      end
      chk("bp_stable", stable, 1);
      chk("bp_byte2_data", d, 8'hC1);
      chk("bp_no_loads", ld0_cnt + ld1_cnt - l0, 0);
      rdy_mode = 0;
      wait_done(200, "bp");

      // Short packet via timeout
      @(posedge clk); #1;
      h = hs_cnt; max_len = 0;
      ba = '{8'h31, 8'h32, 8'h33, 8'h00};
      issue_round(ba, 3, bb, 0);
      wait_done(200, "short");
      chk("short_len", hs_cnt - h, 3);
      chk("short_max_len", max_len, 3);

      // Reset mid-packet: ch0 first (pointer->0), then ch1 wins a tie and is aborted
      apply_reset();
      ba = '{8'h41, 8'h42, 8'h43, 8'h44};
      issue_round(ba, 4, bb, 0);
      wait_done(200, "pre_abort");
      @(posedge clk); #1;
      bb = '{8'h51, 8'h52, 8'h53, 8'h54};
      issue_round(ba, 4, bb, 4);
      h = 0;
      for (int i = 0; i < 200 && h < 2; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            h++;
            if (h == 1) chk("abort_owner", tx_ch, 1);
         end
      end
      chk("abort_two_bytes", h, 2);
      @(posedge clk); #1 rst = 1;
      #1;
      check_reset_outs("abort");
      l0 = ld0_cnt + ld1_cnt;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("abort_no_loads", ld0_cnt + ld1_cnt - l0, 0);
      mptr = 1;
      @(posedge clk); #1;
      issue_round(ba, 4, bb, 4);
      got = -1;
      for (int i = 0; i < 50 && got < 0; i++) begin
         @(negedge clk);
         if (ch0_load) got = 0;
         else if (ch1_load) got = 1;
      end
      chk("abort_next_grant", got, 0);
      wait_done(300, "post_abort");

      // Randomized rounds with random back-pressure
      apply_reset();
      rdy_mode = 1;
      max_len = 0;
      for (int r = 0; r < 30; r++) begin
         n0 = $urandom_range(0, 4);
         n1 = $urandom_range(0, 4);
         for (int k = 0; k < 4; k++) begin
            ba[k] = 8'($urandom);
            bb[k] = 8'($urandom);
         end
         @(posedge clk); #1;
         issue_round(ba, n0, bb, n1);
         wait_done(600, "rand");
      end
      chk("rand_max_len_le_maxpkt", (max_len <= 4) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/usb_in_arbiter.md
USB_IN_ARBITER -- requirements
Module: usb_in_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 8, data width of both channel FIFOs and of the tx port.
- PTRWIDTH, 2, FIFO pointer width; usedw inputs are PTRWIDTH+1 bits.
- MAXPKT, 4, maximum bytes per USB IN packet.
- TIMEOUT, 16, cycles a non-empty, non-full-packet channel waits before a short-packet flush.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- ch0_empty, in, 1, channel 0 FIFO empty.
- ch0_usedw, in, PTRWIDTH+1, channel 0 FIFO fill level.
- ch0_dout, in, WIDTH, channel 0 FIFO read data.
- ch0_fifo_valid, in, 1, channel 0 read data valid.
- ch0_load, out, 1, channel 0 FIFO read strobe.
- ch1_empty, ch1_usedw, ch1_dout, ch1_fifo_valid, ch1_load: same as channel 0, for channel 1.
- tx_data, out, WIDTH, byte to the USB IN endpoint.
- tx_valid, out, 1, tx_data valid.
- tx_last, out, 1, final byte of the current packet.
- tx_ch, out, 1, channel that owns the current packet.
- tx_ready, in, 1, endpoint accepts the byte.
- busy, out, 1, packet in progress (state != IDLE).

Function
REQ-003 The block shall share one USB IN endpoint between two channel FIFOs, one packet at a time; packets from different channels shall never interleave.

REQ-004 FSM states shall be IDLE, LOAD, WAIT and SEND, with these transitions:
- IDLE->LOAD when any channel is eligible.
- LOAD->WAIT unconditionally.
- WAIT->SEND when the granted chN_fifo_valid=1.
- SEND->LOAD on a tx_ready handshake of a non-last byte.
- SEND->IDLE on a tx_ready handshake of a last byte.

REQ-005 A channel shall be eligible when chN_usedw >= MAXPKT, or when chN_empty=0 and its age counter equals TIMEOUT.

REQ-006 Each channel shall have an age counter with these rules:
- Clears when chN_empty=1 or when the channel is granted.
- Otherwise increments by 1 per cycle.
- Saturates at TIMEOUT.

REQ-007 Arbitration shall be round-robin on a last-grant pointer:
- If both channels are eligible in IDLE, grant the channel that is not last-grant.
- If one channel is eligible, grant it.
- The pointer updates to the granted channel on SEND->IDLE.

REQ-008 tx_ch shall latch the granted channel on IDLE->LOAD and hold it until the next grant.

REQ-009 In LOAD the block shall assert exactly one granted chN_load for one cycle; the other load shall stay 0.

REQ-010 In WAIT, on chN_fifo_valid=1, the block shall:
- Capture chN_dout into tx_data.
- Assert tx_valid.
- Set tx_last=1 if (byte count + 1 == MAXPKT) or chN_empty=1 in that cycle.

REQ-011 tx_valid, tx_data and tx_last shall hold stable in SEND until tx_ready=1; tx_valid shall deassert in the cycle after the handshake.

REQ-012 The byte counter shall be $clog2(MAXPKT)+1 bits wide, clear on IDLE->LOAD, and increment on each handshake; a packet shall never exceed MAXPKT bytes.

REQ-013 Boundary conditions:
- A channel that becomes empty mid-packet ends the packet early (short packet, tx_last on the final byte).
- A tx_ready held low stalls the FSM indefinitely without further loads.
- Eligibility changes during a packet do not preempt it.
- Throughput is at most one byte per 3 cycles.

Reset
REQ-014 While rst=1, asynchronously:
- FSM=IDLE.
- ch0_load=ch1_load=0.
- tx_valid=0, tx_last=0, tx_data=0, tx_ch=0, busy=0.
- Byte counter=0 and both age counters=0.
- Last-grant pointer=1, so channel 0 wins the first tie.

REQ-015 Reset asserted mid-packet shall abort the packet with no further loads; after release the block shall resume in IDLE, and any partially sent packet is not resumed.

Verification
REQ-016 Directed scenarios the bench shall cover:
- Full packet: ch0 has 4 bytes 8'hAA,11,22,33, ch1 empty, tx_ready=1 -> 4 bytes in order on tx_data, tx_ch=0, tx_last only on 8'h33, 4 ch0_load pulses.
- Tie: both channels hold 4 bytes after reset -> ch0 packet then ch1 packet; tx_last is 1 on exactly 1 of each 4 bytes.
- Timeout: ch1 holds 1 byte 8'h5A -> no load for 16 cycles, then a single-byte packet 8'h5A with tx_last=1, tx_ch=1.
- Back-pressure: tx_ready=0 for 10 cycles during byte 2 -> tx_data/tx_valid/tx_last stable, no load pulses, then the packet completes normally.
- Short packet: ch0 holds 3 bytes plus its timeout -> 3 bytes with tx_last on the 3rd; byte count never reaches 4.
- Reset mid-packet: rst pulse after byte 2 -> all outputs at reset values in the same cycle, busy=0; the next grant goes to ch0.
